// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM with byte lanes,
// optional wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  // Any illegal size, misalignment or out-of-range word index is an ERROR.
  function automatic logic addr_error(input logic [31:0] addr, input logic [2:0] size);
    logic err;
    case (size)
      3'd0:    err = 1'b0;
      3'd1:    err = addr[0];
      3'd2:    err = (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    err = err | ((addr >> (AW + 2)) != 32'd0);
    return err;
  endfunction

  // Little-endian lane enables for a transfer of the given size and offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] offs);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << offs;
      3'd1:    be = offs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  logic [31:0]   mem [MEM_DEPTH];
  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    wait_cnt_r;
  logic [3:0]    wait_cnt_nxt_s;
  logic          wr_pend_r;
  logic [AW-1:0] waddr_r;
  logic [3:0]    be_r;
  logic          accept_s;
  logic          err_s;
  logic          commit_s;
  logic [AW-1:0] raddr_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   rd_fwd_s;
  logic          ready_nxt_s;
  logic          resp_nxt_s;
  logic          unused_s;

  assign unused_s = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // HREADYOUT low (wait/ERR1) blocks accepts even if HREADY is driven high elsewhere.
  assign accept_s = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign err_s    = addr_error(HADDR, HSIZE);
  assign commit_s = (state_r == S_DATA) & wr_pend_r & ~HRESET;
  assign raddr_s  = HADDR[AW+1:2];
  assign rd_word_s = mem[raddr_s];

  // Merge the committing write into a read of the same word.
  always_comb begin
    rd_fwd_s = rd_word_s;
    if (commit_s && (waddr_r == raddr_s)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          rd_fwd_s[8*i +: 8] = HWDATA[8*i +: 8];
        end else begin
          rd_fwd_s[8*i +: 8] = rd_word_s[8*i +: 8];
        end
      end
    end else begin
      rd_fwd_s = rd_word_s;
    end
  end

  // State and wait-counter register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state logic; IDLE, DATA and ERR2 may take a pipelined accept.
  always_comb begin
    state_nxt_s    = S_IDLE;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      S_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s    = S_WAIT;
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
        end
      end
      S_ERR1: state_nxt_s = S_ERR2;
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_nxt_s = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt_s = S_DATA;
          end else begin
            state_nxt_s    = S_WAIT;
            wait_cnt_nxt_s = WAIT_INIT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Response decode from the upcoming state, registered below.
  always_comb begin
    ready_nxt_s = 1'b1;
    resp_nxt_s  = 1'b0;
    case (state_nxt_s)
      S_WAIT: begin
        ready_nxt_s = 1'b0;
        resp_nxt_s  = 1'b0;
      end
      S_ERR1: begin
        ready_nxt_s = 1'b0;
        resp_nxt_s  = 1'b1;
      end
      S_ERR2: begin
        ready_nxt_s = 1'b1;
        resp_nxt_s  = 1'b1;
      end
      default: begin
        ready_nxt_s = 1'b1;
        resp_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered response outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      HREADYOUT <= ready_nxt_s;
      HRESP     <= resp_nxt_s;
    end
  end

  // Read data: loaded at a good accept, held through the wait cycles, else zero.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA <= 32'd0;
    end else if (accept_s && !err_s) begin
      HRDATA <= rd_fwd_s;
    end else if (state_r == S_WAIT) begin
      HRDATA <= HRDATA;
    end else begin
      HRDATA <= 32'd0;
    end
  end

  // Latch the pending write target at accept; erroneous writes never pend.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_r <= 1'b0;
      waddr_r   <= '0;
      be_r      <= 4'b0000;
    end else if (accept_s) begin
      wr_pend_r <= HWRITE & ~err_s;
      waddr_r   <= raddr_s;
      be_r      <= byte_enables(HSIZE, HADDR[1:0]);
    end else begin
      wr_pend_r <= wr_pend_r;
      waddr_r   <= waddr_r;
      be_r      <= be_r;
    end
  end

  // SRAM byte-lane write at the end of the data phase; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem[waddr_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: a zero-wait and a two-wait-state instance share the bus
// inputs; each sees its own HREADYOUT as HREADY.
module tb_ahb_lite_sram_slave;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2, resp0, resp2;

  int n_cmp = 0;
  int n_err = 0;

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(ready0), .HWDATA(HWDATA),
    .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(ready2), .HWDATA(HWDATA),
    .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic sel, input logic [31:0] a, input logic w,
                    input logic [2:0] sz, input logic [1:0] tr);
    HSEL   = sel;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HTRANS = tr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1; HWDATA = 32'd0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick(); tick();
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_resp",  {31'd0, resp0},  32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    HRESET = 1'b0;

    // Preload words 0..7 with back-to-back writes.
    for (int i = 0; i < 8; i++) begin
      ap(1'b1, 32'(4 * i), 1'b1, 3'd2, 2'd2);
      tick();
      HWDATA = 32'h1000_0000 + 32'(i);
    end
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();

    // Word write then separate read of 0x4.
    ap(1'b1, 32'h4, 1'b1, 3'd2, 2'd2);
    tick();
    chk("wr_ready", {31'd0, ready0}, 32'd1);
    chk("wr_resp",  {31'd0, resp0},  32'd0);
    HWDATA = 32'hAABB_CCDD;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("idle_rdata", rdata0, 32'd0);
    ap(1'b1, 32'h4, 1'b0, 3'd2, 2'd2);
    tick();
    chk("rd_word4", rdata0, 32'hAABB_CCDD);
    chk("rd_ready", {31'd0, ready0}, 32'd1);

    // Byte write 0x11 to 0x5, halfword 0x2233 to 0x6.
    ap(1'b1, 32'h5, 1'b1, 3'd0, 2'd2);
    tick();
    HWDATA = 32'h0000_1100;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    ap(1'b1, 32'h4, 1'b0, 3'd2, 2'd2);
    tick();
    chk("rd_after_byte", rdata0, 32'hAABB_11DD);
    ap(1'b1, 32'h6, 1'b1, 3'd1, 2'd2);
    tick();
    HWDATA = 32'h2233_0000;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    ap(1'b1, 32'h4, 1'b0, 3'd2, 2'd2);
    tick();
    chk("rd_after_half", rdata0, 32'h2233_11DD);
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();

    // Write 0x8 immediately followed by read 0x8: forwarded data.
    ap(1'b1, 32'h8, 1'b1, 3'd2, 2'd2);
    tick();
    chk("b2b_wr_ready", {31'd0, ready0}, 32'd1);
    HWDATA = 32'h0000_00FF;
    ap(1'b1, 32'h8, 1'b0, 3'd2, 2'd2);
    tick();
    chk("fwd_rdata", rdata0, 32'h0000_00FF);
    chk("fwd_ready", {31'd0, ready0}, 32'd1);
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("after_rd_rdata", rdata0, 32'd0);

    // Misaligned word write to 0x2.
    ap(1'b1, 32'h2, 1'b1, 3'd2, 2'd2);
    tick();
    chk("mis_err1_ready", {31'd0, ready0}, 32'd0);
    chk("mis_err1_resp",  {31'd0, resp0},  32'd1);
    chk("mis_err1_rdata", rdata0, 32'd0);
    HWDATA = 32'hDEAD_BEEF;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("mis_err2_ready", {31'd0, ready0}, 32'd1);
    chk("mis_err2_resp",  {31'd0, resp0},  32'd1);
    tick();
    chk("mis_done_resp", {31'd0, resp0}, 32'd0);

    // Read beyond the memory (MEM_DEPTH*4 = 0x400).
    ap(1'b1, 32'h400, 1'b0, 3'd2, 2'd2);
    tick();
    chk("oor_err1_ready", {31'd0, ready0}, 32'd0);
    chk("oor_err1_resp",  {31'd0, resp0},  32'd1);
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("oor_err2_ready", {31'd0, ready0}, 32'd1);
    chk("oor_err2_resp",  {31'd0, resp0},  32'd1);
    chk("oor_err2_rdata", rdata0, 32'd0);
    tick();

    // Burst with a BUSY beat and a trailing IDLE carrying write attributes.
    ap(1'b1, 32'hC, 1'b1, 3'd2, 2'd2);
    tick();
    HWDATA = 32'hCAFE_F00D;
    ap(1'b1, 32'h10, 1'b1, 3'd2, 2'd1);
    tick();
    chk("busy_ready", {31'd0, ready0}, 32'd1);
    chk("busy_resp",  {31'd0, resp0},  32'd0);
    HWDATA = 32'hFFFF_FFFF;
    ap(1'b1, 32'h10, 1'b1, 3'd2, 2'd3);
    tick();
    HWDATA = 32'h5566_7788;
    ap(1'b1, 32'h14, 1'b1, 3'd2, 2'd0);
    tick();
    chk("idle_ready", {31'd0, ready0}, 32'd1);
    HWDATA = 32'hBAD0_BAD0;
    ap(1'b1, 32'hC, 1'b0, 3'd2, 2'd2);
    tick();
    chk("rd_c", rdata0, 32'hCAFE_F00D);
    ap(1'b1, 32'h10, 1'b0, 3'd2, 2'd3);
    tick();
    chk("rd_10", rdata0, 32'h5566_7788);
    ap(1'b1, 32'h14, 1'b0, 3'd2, 2'd3);
    tick();
    chk("rd_14_untouched", rdata0, 32'h1000_0005);
    ap(1'b1, 32'h0, 1'b0, 3'd2, 2'd2);
    tick();
    chk("rd_0_untouched", rdata0, 32'h1000_0000);
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick(); tick(); tick();

    // Two-wait-state instance: write then read 0x20.
    ap(1'b1, 32'h20, 1'b1, 3'd2, 2'd2);
    tick();
    chk("ws_wr_w1", {31'd0, ready2}, 32'd0);
    HWDATA = 32'h0BAD_CAFE;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("ws_wr_w2", {31'd0, ready2}, 32'd0);
    tick();
    chk("ws_wr_data", {31'd0, ready2}, 32'd1);
    tick();
    ap(1'b1, 32'h20, 1'b0, 3'd2, 2'd2);
    tick();
    chk("ws_rd_w1_ready", {31'd0, ready2}, 32'd0);
    chk("ws_rd_w1_rdata", rdata2, 32'h0BAD_CAFE);
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    chk("ws_rd_w2_ready", {31'd0, ready2}, 32'd0);
    chk("ws_rd_w2_rdata", rdata2, 32'h0BAD_CAFE);
    tick();
    chk("ws_rd_data_ready", {31'd0, ready2}, 32'd1);
    chk("ws_rd_data_resp",  {31'd0, resp2},  32'd0);
    chk("ws_rd_data_rdata", rdata2, 32'h0BAD_CAFE);
    tick();
    chk("ws_rd_after", rdata2, 32'd0);

    // Reset during the wait phase of a write to 0x20.
    ap(1'b1, 32'h20, 1'b1, 3'd2, 2'd2);
    tick();
    HWDATA = 32'hFFFF_0000;
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick();
    HRESET = 1'b1;
    tick();
    chk("midrst_ready", {31'd0, ready2}, 32'd1);
    chk("midrst_resp",  {31'd0, resp2},  32'd0);
    chk("midrst_rdata", rdata2, 32'd0);
    HRESET = 1'b0;
    tick(); tick();
    ap(1'b1, 32'h20, 1'b0, 3'd2, 2'd2);
    tick();
    ap(1'b0, 32'd0, 1'b0, 3'd2, 2'd0);
    tick(); tick();
    chk("midrst_no_commit", rdata2, 32'h0BAD_CAFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave with a word-addressed on-chip SRAM, sitting directly downstream of the AHB-Lite Master.
- Consumes the Master's address/control/write-data outputs and produces HRDATA/HREADYOUT/HRESP, which are returned to the Master's HRDATA/HREADY/HRESP inputs.
- Supports byte/halfword/word accesses, a programmable wait-state count and the two-cycle ERROR response.
- Also serves as the bus-functional target for Master regression.

Parameters:
- MEM_DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- WAIT_STATES, 0: number of HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address; word index = HADDR[31:2].
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  0=byte, 1=halfword, 2=word.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready; an address phase is valid only when HREADY=1.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  registered read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, latch address, HWRITE and HSIZE.
- No accept for IDLE, BUSY, HSEL=0 or HREADY=0. No transfer occurs and the next cycle responds OKAY with zero wait.
- Error check at accept. ERROR if any of:
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0;
  - HADDR[31:2] >= MEM_DEPTH.
- FSM states:
  - S_IDLE: HREADYOUT=1, HRESP=0.
  - S_WAIT: HREADYOUT=0, HRESP=0; wait counter decrements each cycle.
  - S_DATA: HREADYOUT=1, HRESP=0; final data-phase cycle.
  - S_ERR1: HREADYOUT=0, HRESP=1.
  - S_ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions on accept:
  - If erroneous: go to S_ERR1, then S_ERR2 unconditionally.
  - Else if WAIT_STATES=0: go to S_DATA.
  - Else: go to S_WAIT with counter=WAIT_STATES-1. Leave S_WAIT for S_DATA when the counter reaches 0.
- Pipelining:
  - In S_DATA, S_ERR2 and S_IDLE a new accept may occur in the same cycle; the next state follows the accept rules above.
  - With no accept, the FSM returns to S_IDLE.
  - Back-to-back zero-wait transfers therefore complete one per cycle.
- Write commit:
  - The write commits to memory at the rising edge ending the S_DATA cycle, using HWDATA.
  - Byte-lane enables are derived from the latched HSIZE and HADDR[1:0], little-endian: byte lane n = HWDATA[8n+7:8n].
  - Erroneous writes never touch memory.
- Read data:
  - HRDATA holds the full addressed word, loaded at accept. It stays stable through S_WAIT/S_DATA and is 0 in all other cycles, including error responses.
  - Forwarding: if a read is accepted in the same cycle that a write commits to the same word, HRDATA returns the merged word (new bytes on enabled lanes, old bytes elsewhere).
- Reset (HRESET=1 at an edge):
  - Effects: state=S_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, any pending write discarded.
  - Reset applies mid-wait or mid-error identically.
  - Memory contents are not reset.
- HSEL deasserted during an in-flight data phase does not abort it.

Test Plan:
- Reset, then word write 0xAABB_CCDD to 0x4 and read 0x4 (WAIT_STATES=0) -> write completes with HREADYOUT=1, HRESP=0; read data phase shows HRDATA=0xAABB_CCDD.
- Byte write 0x11 to 0x5 after the above, then word read 0x4 -> HRDATA=0xAABB_11DD. Halfword write 0x2233 to 0x6 -> next read gives 0x2233_11DD.
- Back-to-back NONSEQ write 0x0000_00FF to 0x8 immediately followed by a read of 0x8 -> the read data phase returns 0x0000_00FF via forwarding; one transfer completes per cycle.
- WAIT_STATES=2: word read -> HREADYOUT low exactly 2 cycles, then high with correct HRDATA. HRDATA stable across the wait cycles.
- Misaligned word write to 0x2, and a read of address MEM_DEPTH*4 -> each gives one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1. Memory unchanged; HRDATA=0.
- BUSY and IDLE cycles inside a burst, plus HRESET asserted during S_WAIT -> BUSY/IDLE give OKAY zero-wait with no memory access. Reset forces HREADYOUT=1, HRESP=0, HRDATA=0 at the next edge, and the interrupted write is not committed.
